audio_vol_ramp: RTL and testbench

AUDIO_VOL_RAMP -- requirements
Module: audio_vol_ramp

---
 rtl/audio_vol_ramp.sv | 167 ++++++++++++++++
 tb/tb_audio_vol_ramp.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_vol_ramp.sv
`default_nettype none
// ============================================================================
// Module      : audio_vol_ramp
// Description : Stereo volume control with a per-sample linear volume ramp
//               toward a (mutable) target, a two-stage scale/saturate
//               pipeline, and a registered decimal volume readout.
// Revision    : 1.0 - initial release
// ============================================================================
module audio_vol_ramp #(
    parameter int DATA_W  = 16,
    parameter int VOL_W   = 12,
    parameter int FRAC    = 11,
    parameter int STEP    = 8,
    parameter int VOL_RST = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              vld_in,
    input  logic [DATA_W-1:0] lft_in,
    input  logic [DATA_W-1:0] rht_in,
    input  logic [VOL_W-1:0]  vol_tgt,
    input  logic              mute,
    output logic [DATA_W-1:0] lft_out,
    output logic [DATA_W-1:0] rht_out,
    output logic              vld_out,
    output logic [VOL_W-1:0]  vol_cur,
    output logic [7:0]        vol_dec,
    output logic              sat
);

    // Product width: signed sample times a zero-extended (hence positive) volume.
    localparam int c_pw = DATA_W + VOL_W + 1;

    localparam logic [1:0] c_st_hold = 2'd0;
    localparam logic [1:0] c_st_up   = 2'd1;
    localparam logic [1:0] c_st_down = 2'd2;

    localparam logic [VOL_W:0]   c_step    = (VOL_W+1)'(STEP);
    localparam logic [VOL_W-1:0] c_vol_rst = VOL_W'(VOL_RST);

    localparam logic signed [c_pw-1:0] c_sat_max = {{(c_pw-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [c_pw-1:0] c_sat_min = {{(c_pw-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    // Display value: (vol*100) >> FRAC, clamped to 8 bits.
    function automatic logic [7:0] f_dec(input logic [VOL_W-1:0] v);
        logic [VOL_W+6:0] p;
        p = (VOL_W+7)'(v) * (VOL_W+7)'(100);
        p = p >> FRAC;
        return (|p[VOL_W+6:8]) ? 8'hFF : p[7:0];
    endfunction

    logic [VOL_W-1:0] r_vol;
    logic [7:0]       r_vol_dec;
    logic             r_v1;
    logic signed [c_pw-1:0] r_prod_l;
    logic signed [c_pw-1:0] r_prod_r;
    logic [DATA_W-1:0] r_lft;
    logic [DATA_W-1:0] r_rht;
    logic              r_vld;
    logic              r_sat;

    logic [VOL_W-1:0] w_tgt;
    logic [1:0]       w_state;
    logic [VOL_W:0]   w_up_sum;
    logic [VOL_W:0]   w_dn_dif;
    logic [VOL_W-1:0] w_vol_nxt;
    logic signed [c_pw-1:0] w_lft_x;
    logic signed [c_pw-1:0] w_rht_x;
    logic signed [c_pw-1:0] w_vol_x;
    logic signed [c_pw-1:0] w_sh_l;
    logic signed [c_pw-1:0] w_sh_r;
    logic w_hi_l, w_lo_l, w_hi_r, w_lo_r;

    assign w_tgt = mute ? '0 : vol_tgt;

    // Ramp direction is re-derived every cycle, so target changes take effect immediately.
    always_comb begin
        w_state = c_st_hold;
        if (r_vol < w_tgt)
            w_state = c_st_up;
        else if (r_vol > w_tgt)
            w_state = c_st_down;
    end

    // Next volume: one STEP toward the target, clamped so it never overshoots or wraps.
    always_comb begin
        w_up_sum  = {1'b0, r_vol} + c_step;
        w_dn_dif  = {1'b0, r_vol} - c_step;
        w_vol_nxt = r_vol;
        case (w_state)
            c_st_up:
                w_vol_nxt = (w_up_sum > {1'b0, w_tgt}) ? w_tgt : w_up_sum[VOL_W-1:0];
            c_st_down:
                w_vol_nxt = (w_dn_dif[VOL_W] || (w_dn_dif < {1'b0, w_tgt})) ? w_tgt : w_dn_dif[VOL_W-1:0];
            default:
                w_vol_nxt = r_vol;
        endcase
    end

    // Volume advances only on accepted samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_vol <= c_vol_rst;
        else if (vld_in)
            r_vol <= w_vol_nxt;
    end

    // Display value tracks vol_cur one cycle later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_vol_dec <= f_dec(c_vol_rst);
        else
            r_vol_dec <= f_dec(r_vol);
    end

    assign w_lft_x = {{(VOL_W+1){lft_in[DATA_W-1]}}, lft_in};
    assign w_rht_x = {{(VOL_W+1){rht_in[DATA_W-1]}}, rht_in};
    assign w_vol_x = {{DATA_W{1'b0}}, 1'b0, r_vol};

    // Stage 1: multiply by the pre-update volume of the accepting cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1     <= 1'b0;
            r_prod_l <= '0;
            r_prod_r <= '0;
        end else begin
            r_v1 <= vld_in;
            if (vld_in) begin
                r_prod_l <= w_lft_x * w_vol_x;
                r_prod_r <= w_rht_x * w_vol_x;
            end
        end
    end

    assign w_sh_l = r_prod_l >>> FRAC;
    assign w_sh_r = r_prod_r >>> FRAC;
    assign w_hi_l = (w_sh_l > c_sat_max);
    assign w_lo_l = (w_sh_l < c_sat_min);
    assign w_hi_r = (w_sh_r > c_sat_max);
    assign w_lo_r = (w_sh_r < c_sat_min);

    // Stage 2: floor-shift, clip to the sample range, hold results between strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld <= 1'b0;
            r_lft <= '0;
            r_rht <= '0;
            r_sat <= 1'b0;
        end else begin
            r_vld <= r_v1;
            if (r_v1) begin
                r_lft <= w_hi_l ? c_sat_max[DATA_W-1:0] : (w_lo_l ? c_sat_min[DATA_W-1:0] : w_sh_l[DATA_W-1:0]);
                r_rht <= w_hi_r ? c_sat_max[DATA_W-1:0] : (w_lo_r ? c_sat_min[DATA_W-1:0] : w_sh_r[DATA_W-1:0]);
                r_sat <= w_hi_l | w_lo_l | w_hi_r | w_lo_r;
            end
        end
    end

    assign lft_out = r_lft;
    assign rht_out = r_rht;
    assign vld_out = r_vld;
    assign sat     = r_sat;
    assign vol_cur = r_vol;
    assign vol_dec = r_vol_dec;

endmodule
`default_nettype wire

// File: tb/tb_audio_vol_ramp.sv
`default_nettype none
// ============================================================================
// Module      : tb_audio_vol_ramp
// Description : Self-checking bench for audio_vol_ramp (default parameters)
//               against a cycle-level behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_audio_vol_ramp;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        vld_in = 1'b0;
    logic        mute = 1'b0;
    logic [15:0] lft_in = '0;
    logic [15:0] rht_in = '0;
    logic [11:0] vol_tgt = '0;
    logic [15:0] lft_out;
    logic [15:0] rht_out;
    logic        vld_out;
    logic [11:0] vol_cur;
    logic [7:0]  vol_dec;
    logic        sat;

    audio_vol_ramp dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .vld_in  (vld_in),
        .lft_in  (lft_in),
        .rht_in  (rht_in),
        .vol_tgt (vol_tgt),
        .mute    (mute),
        .lft_out (lft_out),
        .rht_out (rht_out),
        .vld_out (vld_out),
        .vol_cur (vol_cur),
        .vol_dec (vol_dec),
        .sat     (sat)
    );

    always #5 clk = ~clk;

    int errs = 0;
    int checks = 0;
    int cyc = 0;

    // Behavioural model state
    int m_vol = 0;
    int m_dec = 0;
    bit m_vld = 0;
    int m_l = 0;
    int m_r = 0;
    bit m_sat = 0;

    typedef struct {
        int due;
        int l;
        int r;
        bit s;
    } ent_t;
    ent_t q[$];

    // Drive one cycle and advance the model at the clock edge.
    task automatic tick(input bit v, input int l, input int r);
        longint pl, pr;
        int tgt;
        ent_t e;
        vld_in = v;
        lft_in = l[15:0];
        rht_in = r[15:0];
        @(posedge clk);
        cyc++;
        tgt = mute ? 0 : int'(vol_tgt);
        m_dec = (m_vol * 100) / 2048;
        if (m_dec > 255) m_dec = 255;
        if (v) begin
            pl = (longint'(l) * m_vol) >>> 11;
            pr = (longint'(r) * m_vol) >>> 11;
            e.s = 0;
            if (pl > 32767) begin pl = 32767; e.s = 1; end
            if (pl < -32768) begin pl = -32768; e.s = 1; end
            if (pr > 32767) begin pr = 32767; e.s = 1; end
            if (pr < -32768) begin pr = -32768; e.s = 1; end
            e.l = int'(pl);
            e.r = int'(pr);
            e.due = cyc + 1;
            q.push_back(e);
            if (m_vol < tgt) m_vol = (m_vol + 8 > tgt) ? tgt : m_vol + 8;
            else if (m_vol > tgt) m_vol = (m_vol - 8 < tgt) ? tgt : m_vol - 8;
        end
        m_vld = 0;
        if (q.size() > 0 && q[0].due == cyc) begin
            e = q.pop_front();
            m_vld = 1;
            m_l = e.l;
            m_r = e.r;
            m_sat = e.s;
        end
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        vld_in = 1'b1;
        lft_in = 16'd1234;
        rht_in = 16'd4321;
        #1;
        m_vol = 0; m_dec = 0; m_vld = 0; m_l = 0; m_r = 0; m_sat = 0;
        q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (vol_cur !== 12'd0) begin errs++; $display("FAIL reset_vol_cur got=%0d exp=0", vol_cur); end
        checks++; if (vol_dec !== 8'd0) begin errs++; $display("FAIL reset_vol_dec got=%0d exp=0", vol_dec); end
        checks++; if (vld_out !== 1'b0) begin errs++; $display("FAIL reset_vld_out got=%0b exp=0", vld_out); end
        checks++; if (lft_out !== 16'd0 || rht_out !== 16'd0) begin errs++; $display("FAIL reset_data got=%0d/%0d exp=0/0", lft_out, rht_out); end
        checks++; if (sat !== 1'b0) begin errs++; $display("FAIL reset_sat got=%0b exp=0", sat); end
    endtask

    task automatic test_ramp();
        int exp;
        vol_tgt = 12'd100;
        for (int k = 1; k <= 16; k++) begin
            tick(1'b1, 0, 0);
            exp = (8 * k > 100) ? 100 : 8 * k;
            checks++; if (int'(vol_cur) !== exp) begin errs++; $display("FAIL ramp_vol_cur step=%0d got=%0d exp=%0d", k, vol_cur, exp); end
        end
        checks++; if (int'(vol_dec) !== m_dec) begin errs++; $display("FAIL ramp_vol_dec got=%0d exp=%0d", vol_dec, m_dec); end
    endtask

    task automatic test_unity();
        vol_tgt = 12'd2048;
        repeat (256) tick(1'b1, 0, 0);
        checks++; if (vol_cur !== 12'd2048) begin errs++; $display("FAIL unity_vol got=%0d exp=2048", vol_cur); end
        tick(1'b0, 0, 0);
        tick(1'b0, 0, 0);
        tick(1'b1, 1000, -1000);
        checks++; if (vld_out !== 1'b0) begin errs++; $display("FAIL unity_early_vld got=%0b exp=0", vld_out); end
        tick(1'b0, 0, 0);
        checks++; if (vld_out !== 1'b1) begin errs++; $display("FAIL unity_vld got=%0b exp=1", vld_out); end
        checks++; if ($signed(lft_out) !== 16'sd1000 || $signed(rht_out) !== -16'sd1000) begin errs++; $display("FAIL unity_data got=%0d/%0d exp=1000/-1000", $signed(lft_out), $signed(rht_out)); end
        checks++; if (vol_dec !== 8'd100) begin errs++; $display("FAIL unity_vol_dec got=%0d exp=100", vol_dec); end
        tick(1'b0, 0, 0);
        checks++; if (vld_out !== 1'b0 || $signed(lft_out) !== 16'sd1000) begin errs++; $display("FAIL unity_hold vld=%0b lft=%0d exp vld=0 lft=1000", vld_out, $signed(lft_out)); end
    endtask

    task automatic test_saturation();
        vol_tgt = 12'd4095;
        repeat (520) tick(1'b1, 0, 0);
        checks++; if (vol_cur !== 12'd4095) begin errs++; $display("FAIL sat_vol got=%0d exp=4095", vol_cur); end
        tick(1'b1, 32767, -32768);
        tick(1'b0, 0, 0);
        checks++; if (lft_out !== 16'h7FFF || rht_out !== 16'h8000) begin errs++; $display("FAIL sat_data got=%0d/%0d exp=32767/-32768", $signed(lft_out), $signed(rht_out)); end
        checks++; if (sat !== 1'b1) begin errs++; $display("FAIL sat_flag got=%0b exp=1", sat); end
        checks++; if (vol_dec !== 8'd199) begin errs++; $display("FAIL sat_vol_dec got=%0d exp=199", vol_dec); end
        tick(1'b1, 100, 100);
        tick(1'b0, 0, 0);
        checks++; if (sat !== 1'b0 || lft_out !== 16'd199) begin errs++; $display("FAIL sat_clear sat=%0b lft=%0d exp sat=0 lft=199", sat, lft_out); end
    endtask

    task automatic test_mute();
        do_reset();
        vol_tgt = 12'd2048;
        repeat (125) tick(1'b1, 0, 0);
        checks++; if (vol_cur !== 12'd1000) begin errs++; $display("FAIL mute_pre got=%0d exp=1000", vol_cur); end
        mute = 1'b1;
        for (int k = 1; k <= 126; k++) begin
            tick(1'b1, 0, 0);
            checks++; if (int'(vol_cur) !== ((1000 - 8 * k < 0) ? 0 : 1000 - 8 * k)) begin errs++; $display("FAIL mute_down step=%0d got=%0d", k, vol_cur); end
        end
        mute = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            tick(1'b1, 0, 0);
            checks++; if (int'(vol_cur) !== 8 * k) begin errs++; $display("FAIL mute_release step=%0d got=%0d exp=%0d", k, vol_cur, 8 * k); end
        end
    endtask

    task automatic test_reset_mid();
        vol_tgt = 12'd500;
        tick(1'b1, 1000, 1000);
        tick(1'b1, 777, 777);
        do_reset();
        checks++; if (vol_cur !== 12'd0 || lft_out !== 16'd0 || rht_out !== 16'd0 || sat !== 1'b0) begin errs++; $display("FAIL rstmid_state vol=%0d l=%0d r=%0d sat=%0b exp all 0", vol_cur, lft_out, rht_out, sat); end
        for (int k = 0; k < 4; k++) begin
            tick(1'b0, 0, 0);
            checks++; if (vld_out !== 1'b0) begin errs++; $display("FAIL rstmid_vld cyc=%0d got=%0b exp=0", k, vld_out); end
        end
    endtask

    task automatic test_trunc_gap();
        do_reset();
        vol_tgt = 12'd1024;
        repeat (128) tick(1'b1, 0, 0);
        checks++; if (vol_cur !== 12'd1024) begin errs++; $display("FAIL trunc_vol got=%0d exp=1024", vol_cur); end
        tick(1'b1, -3, 5);
        tick(1'b0, 0, 0);
        checks++; if ($signed(lft_out) !== -16'sd2 || rht_out !== 16'd2) begin errs++; $display("FAIL trunc_data got=%0d/%0d exp=-2/2", $signed(lft_out), $signed(rht_out)); end
        vol_tgt = 12'd2048;
        repeat (10) tick(1'b0, 0, 0);
        checks++; if (vol_cur !== 12'd1024) begin errs++; $display("FAIL gap_vol got=%0d exp=1024", vol_cur); end
        checks++; if (vld_out !== 1'b0 || $signed(lft_out) !== -16'sd2 || rht_out !== 16'd2) begin errs++; $display("FAIL gap_hold vld=%0b data=%0d/%0d exp 0 -2/2", vld_out, $signed(lft_out), $signed(rht_out)); end
    endtask

    task automatic test_random();
        int l, r;
        do_reset();
        for (int i = 0; i < 800; i++) begin
            if (i % 40 == 0) vol_tgt = 12'($urandom_range(0, 4095));
            if ($urandom_range(0, 31) == 0) mute = ~mute;
            l = int'($urandom_range(0, 65535)) - 32768;
            r = int'($urandom_range(0, 65535)) - 32768;
            tick($urandom_range(0, 3) != 0, l, r);
            checks++; if (int'(vol_cur) !== m_vol) begin errs++; $display("FAIL rnd_vol i=%0d got=%0d exp=%0d", i, vol_cur, m_vol); end
            checks++; if (int'(vol_dec) !== m_dec) begin errs++; $display("FAIL rnd_dec i=%0d got=%0d exp=%0d", i, vol_dec, m_dec); end
            checks++; if (vld_out !== m_vld) begin errs++; $display("FAIL rnd_vld i=%0d got=%0b exp=%0b", i, vld_out, m_vld); end
            checks++; if (int'($signed(lft_out)) !== m_l || int'($signed(rht_out)) !== m_r || sat !== m_sat) begin
                errs++; $display("FAIL rnd_data i=%0d got=%0d/%0d/%0b exp=%0d/%0d/%0b", i, $signed(lft_out), $signed(rht_out), sat, m_l, m_r, m_sat);
            end
        end
        mute = 1'b0;
    endtask

    task automatic test_back_to_back();
        int l, r;
        vol_tgt = 12'd3000;
        for (int i = 0; i < 12; i++) begin
            l = int'($urandom_range(0, 65535)) - 32768;
            r = int'($urandom_range(0, 65535)) - 32768;
            tick(1'b1, l, r);
            if (i > 0) begin
                checks++; if (vld_out !== 1'b1 || int'($signed(lft_out)) !== m_l || int'($signed(rht_out)) !== m_r || sat !== m_sat) begin
                    errs++; $display("FAIL b2b i=%0d got vld=%0b %0d/%0d/%0b exp 1 %0d/%0d/%0b", i, vld_out, $signed(lft_out), $signed(rht_out), sat, m_l, m_r, m_sat);
                end
            end
        end
        tick(1'b0, 0, 0);
        checks++; if (vld_out !== 1'b1 || int'($signed(lft_out)) !== m_l) begin errs++; $display("FAIL b2b_last got vld=%0b lft=%0d exp 1 %0d", vld_out, $signed(lft_out), m_l); end
        tick(1'b0, 0, 0);
        checks++; if (vld_out !== 1'b0) begin errs++; $display("FAIL b2b_end got=%0b exp=0", vld_out); end
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_unity();
        test_saturation();
        test_mute();
        test_reset_mid();
        test_trunc_gap();
        test_random();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
`default_nettype wire
